commit_trace_buf: RTL and testbench

COMMIT_TRACE_BUF -- requirements
Module: commit_trace_buf

---
 rtl/commit_trace_buf_pkg.sv | 56 +++++
 rtl/commit_trace_buf_trace_ram.sv | 36 +++
 rtl/commit_trace_buf.sv | 158 +++++++++++++++
 tb/tb_commit_trace_buf.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_trace_buf_pkg.sv
// ---------------------------------------------------------------------------
// commit_trace_buf_pkg
// Shared instruction definitions for the commit trace buffer: base RV32
// opcodes, the two trap encodings that freeze capture, the halt_code values,
// the trace FSM state encoding and the stored entry layout.
// No ports (package).
// ---------------------------------------------------------------------------
package commit_trace_buf_pkg;

    // Base RV32I major opcodes (inst[6:0]).
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Full trap encodings that stop trace capture.
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;

    typedef enum logic [1:0] {
        HALT_NONE   = 2'b00,
        HALT_EBREAK = 2'b01,
        HALT_ECALL  = 2'b10
    } halt_code_e;

    typedef enum logic [1:0] {
        ST_CAPTURE = 2'b00,
        ST_HALTED  = 2'b01,
        ST_DRAIN   = 2'b10,
        ST_DONE    = 2'b11
    } trace_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } trace_entry_t;

    // Classify a retiring instruction: HALT_NONE unless it is an exact trap encoding.
    function automatic halt_code_e trap_code(input logic [31:0] inst);
        halt_code_e code;
        code = HALT_NONE;
        if (inst == INST_EBREAK) begin
            code = HALT_EBREAK;
        end else if (inst == INST_ECALL) begin
            code = HALT_ECALL;
        end
        return code;
    endfunction

endpackage

// File: rtl/commit_trace_buf_trace_ram.sv
// ---------------------------------------------------------------------------
// trace_ram
// DEPTH x W storage for the commit trace. One synchronous write port and one
// asynchronous (combinational) read port. Contents are never reset.
// Ports:
//   clk      clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data, mem[raddr_i] in the same cycle
// ---------------------------------------------------------------------------
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int W     = 64
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/commit_trace_buf.sv
// ---------------------------------------------------------------------------
// commit_trace_buf
// Ring buffer of the last DEPTH retired instructions {pc, inst}. Capture runs
// until an ebreak/ecall retires; that instruction is recorded and capture
// freezes. A drain request then replays the stored entries oldest-first over
// a valid/ready port. Draining is non-destructive and can be repeated.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   commit_valid/pc/inst            retirement stream
//   drain_req                       start readout (HALTED or DONE only)
//   rd_valid/rd_ready               readout handshake
//   rd_pc/rd_inst/rd_last           presented entry, last = newest entry
//   halted, halt_code               capture frozen and the trap that froze it
//   entry_count                     stored entries, 0..DEPTH
//   total_commits                   commits accepted since reset
//   state_dbg                       current FSM state (debug visibility)
//
// Readout handshake: an entry transfers on every rising edge where
// rd_valid && rd_ready. While rd_valid=1 and rd_ready=0 the presented entry
// and rd_last stay stable; rd_valid never drops without a transfer except on
// reset.
// ---------------------------------------------------------------------------
module commit_trace_buf
    import commit_trace_buf_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          commit_valid,
    input  logic [31:0]   commit_pc,
    input  logic [31:0]   commit_inst,
    input  logic          drain_req,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [31:0]   rd_pc,
    output logic [31:0]   rd_inst,
    output logic          rd_last,
    output logic          halted,
    output logic [1:0]    halt_code,
    output logic [AW:0]   entry_count,
    output logic [63:0]   total_commits,
    output logic [1:0]    state_dbg
);

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

    trace_state_e  state_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   remaining_q;
    logic [AW:0]   entry_count_q;
    logic [63:0]   total_q;
    logic          halted_q;
    halt_code_e    halt_code_q;
    logic          rd_valid_q;

    trace_entry_t  wr_entry_d;
    trace_entry_t  rd_entry;
    halt_code_e    commit_trap;
    logic          capture_we;

    assign capture_we  = (state_q == ST_CAPTURE) && commit_valid;
    assign commit_trap = trap_code(commit_inst);
    assign wr_entry_d  = '{pc: commit_pc, inst: commit_inst};

    trace_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (64)
    ) u_trace_ram (
        .clk     (clk),
        .we_i    (capture_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry_d),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_CAPTURE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            remaining_q   <= '0;
            entry_count_q <= '0;
            total_q       <= '0;
            halted_q      <= 1'b0;
            halt_code_q   <= HALT_NONE;
            rd_valid_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_CAPTURE: begin
                    if (commit_valid) begin
                        // Pointer width is exactly log2(DEPTH), so the add wraps.
                        wr_ptr_q <= wr_ptr_q + PTR_ONE;
                        if (entry_count_q != CNT_MAX) begin
                            entry_count_q <= entry_count_q + CNT_ONE;
                        end
                        total_q <= total_q + 64'd1;
                        if (commit_trap != HALT_NONE) begin
                            halted_q    <= 1'b1;
                            halt_code_q <= commit_trap;
                            state_q     <= ST_HALTED;
                        end
                    end
                end

                ST_HALTED, ST_DONE: begin
                    if (drain_req) begin
                        // Oldest entry sits entry_count slots behind the write
                        // pointer; with a full buffer that is wr_ptr itself.
                        rd_ptr_q    <= wr_ptr_q - entry_count_q[AW-1:0];
                        remaining_q <= entry_count_q;
                        if (entry_count_q == '0) begin
                            state_q    <= ST_DONE;
                            rd_valid_q <= 1'b0;
                        end else begin
                            state_q    <= ST_DRAIN;
                            rd_valid_q <= 1'b1;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (rd_ready) begin
                        rd_ptr_q    <= rd_ptr_q + PTR_ONE;
                        remaining_q <= remaining_q - CNT_ONE;
                        if (remaining_q == CNT_ONE) begin
                            state_q    <= ST_DONE;
                            rd_valid_q <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_q <= ST_CAPTURE;
                end
            endcase
        end
    end

    // No writes happen outside CAPTURE, so the async read of rd_ptr_q is
    // stable for as long as rd_ptr_q is held during a stall.
    assign rd_valid      = rd_valid_q;
    assign rd_pc         = rd_entry.pc;
    assign rd_inst       = rd_entry.inst;
    assign rd_last       = rd_valid_q && (remaining_q == CNT_ONE);
    assign halted        = halted_q;
    assign halt_code     = halt_code_q;
    assign entry_count   = entry_count_q;
    assign total_commits = total_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_commit_trace_buf.sv
// ---------------------------------------------------------------------------
// tb_commit_trace_buf
// Self-checking bench for commit_trace_buf (DEPTH=16). A queue-based model
// keeps the newest DEPTH {pc,inst} entries oldest-first, plus the commit
// total and halt status; every drain is compared entry by entry against it.
// ---------------------------------------------------------------------------
module tb_commit_trace_buf;
    import commit_trace_buf_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DRAIN_BOUND = 400;

    localparam logic [31:0] TB_EBREAK = 32'h0010_0073;
    localparam logic [31:0] TB_ECALL  = 32'h0000_0073;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          commit_valid;
    logic [31:0]   commit_pc;
    logic [31:0]   commit_inst;
    logic          drain_req;
    logic          rd_valid;
    logic          rd_ready;
    logic [31:0]   rd_pc;
    logic [31:0]   rd_inst;
    logic          rd_last;
    logic          halted;
    logic [1:0]    halt_code;
    logic [AW:0]   entry_count;
    logic [63:0]   total_commits;
    logic [1:0]    state_dbg;

    always #5 clk = ~clk;

    commit_trace_buf #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .commit_valid  (commit_valid),
        .commit_pc     (commit_pc),
        .commit_inst   (commit_inst),
        .drain_req     (drain_req),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_pc         (rd_pc),
        .rd_inst       (rd_inst),
        .rd_last       (rd_last),
        .halted        (halted),
        .halt_code     (halt_code),
        .entry_count   (entry_count),
        .total_commits (total_commits),
        .state_dbg     (state_dbg)
    );

    // ---------------- scoreboard / model ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] model_total;
    logic        model_halted;
    logic [1:0]  model_code;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        model_total  = 64'd0;
        model_halted = 1'b0;
        model_code   = 2'b00;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] x;
        x = $urandom;
        if (x == TB_EBREAK || x == TB_ECALL) x = x ^ 32'h0000_1000;
        return x;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        rst = 1'b1; commit_valid = 1'b0; drain_req = 1'b0; rd_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One cycle of commit stream; the model records only while capturing.
    task automatic step_commit(input logic v, input logic [31:0] pc,
                               input logic [31:0] inst, input logic dreq);
        commit_valid = v; commit_pc = pc; commit_inst = inst; drain_req = dreq;
        @(posedge clk); #1;
        commit_valid = 1'b0; drain_req = 1'b0;
        if (v && !model_halted) begin
            exp_q.push_back({pc, inst});
            if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
            model_total++;
            if (inst == TB_EBREAK) begin
                model_halted = 1'b1; model_code = 2'b01;
            end else if (inst == TB_ECALL) begin
                model_halted = 1'b1; model_code = 2'b10;
            end
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, ".halted"},      64'(halted),        64'(model_halted));
        check({tag, ".halt_code"},   64'(halt_code),     64'(model_code));
        check({tag, ".entry_count"}, 64'(entry_count),   64'(exp_q.size()));
        check({tag, ".total"},       total_commits,      model_total);
    endtask

    // Drain and compare against the model. stall_idx: entry held with
    // rd_ready=0 for three cycles first (-1 none). rst_at: handshake index
    // on which reset is asserted (-1 none); the task returns right after it.
    task automatic drain_check(input string tag, input int stall_pct,
                               input int stall_idx, input int rst_at);
        int i = 0;
        int cyc = 0;
        int stall_cnt = 0;
        logic [63:0] e;
        drain_req = 1'b1;
        @(posedge clk); #1;
        drain_req = 1'b0;
        while (i < exp_q.size() && cyc < DRAIN_BOUND) begin
            e = exp_q[i];
            check({tag, ".rd_valid"}, 64'(rd_valid), 64'd1);
            check({tag, ".rd_pc"},    64'(rd_pc),    64'(e[63:32]));
            check({tag, ".rd_inst"},  64'(rd_inst),  64'(e[31:0]));
            check({tag, ".rd_last"},  64'(rd_last),  64'(i == exp_q.size() - 1));
            if (i == stall_idx && stall_cnt < 3) begin
                rd_ready = 1'b0;
                stall_cnt++;
            end else begin
                rd_ready = ($urandom_range(0, 99) >= stall_pct);
            end
            rst = rd_ready && (i == rst_at);
            @(posedge clk); #1;
            if (rst) begin
                rst = 1'b0; rd_ready = 1'b0;
                model_reset();
                return;
            end
            if (rd_ready) i++;
            cyc++;
        end
        rd_ready = 1'b0;
        check({tag, ".bound"},    64'(cyc < DRAIN_BOUND), 64'd1);
        check({tag, ".end_valid"}, 64'(rd_valid),  64'd0);
        check({tag, ".end_state"}, 64'(state_dbg), 64'(ST_DONE));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] pc;
        rst = 1'b0; commit_valid = 1'b0; commit_pc = '0; commit_inst = '0;
        drain_req = 1'b0; rd_ready = 1'b0;
        model_reset();

        // Reset state.
        apply_reset();
        check("rst.rd_valid", 64'(rd_valid),  64'd0);
        check("rst.rd_last",  64'(rd_last),   64'd0);
        check("rst.state",    64'(state_dbg), 64'(ST_CAPTURE));
        check_status("rst");

        // Five commits then ebreak; drain from HALTED with rd_ready=1.
        for (int k = 0; k < 5; k++) begin
            step_commit(1'b1, 32'h8000_0000 + 32'(4 * k), rand_inst(), 1'b0);
            if ($urandom_range(0, 1) == 1) step_commit(1'b0, 32'h0, rand_inst(), 1'b1);
        end
        step_commit(1'b1, 32'h8000_0014, TB_EBREAK, 1'b0);
        check("ebk.state", 64'(state_dbg), 64'(ST_HALTED));
        check("ebk.count_const", 64'(entry_count), 64'd6);
        check_status("ebk");
        drain_check("ebk_drain", 0, -1, -1);

        // Commits after the halt are ignored; re-drain from DONE replays.
        for (int k = 0; k < 8; k++) step_commit(1'b1, $urandom, rand_inst(), 1'b0);
        check_status("post_halt");
        drain_check("redrain", 0, -1, -1);
        drain_check("redrain2", 40, 2, -1);

        // Overwrite of oldest: 20 commits then ecall, with a 3-cycle stall.
        apply_reset();
        for (int k = 0; k < 20; k++) step_commit(1'b1, 32'(4 * k), rand_inst(), 1'b0);
        step_commit(1'b1, 32'h0000_0050, TB_ECALL, 1'b0);
        check("wrap.total_const", total_commits, 64'd21);
        check("wrap.first_pc_model", exp_q[0][63:32], 64'h14);
        check_status("wrap");
        drain_check("wrap_drain", 25, 5, -1);

        // Reset during the third drain handshake.
        for (int k = 0; k < 4; k++) step_commit(1'b1, $urandom, rand_inst(), 1'b0);
        check_status("pre_abort");
        apply_reset();
        for (int k = 0; k < 6; k++) step_commit(1'b1, 32'h1000 + 32'(4 * k), rand_inst(), 1'b0);
        step_commit(1'b1, 32'h1018, TB_EBREAK, 1'b0);
        drain_check("abort_drain", 0, -1, 2);
        check("abort.rd_valid", 64'(rd_valid),  64'd0);
        check("abort.state",    64'(state_dbg), 64'(ST_CAPTURE));
        check_status("abort");
        for (int k = 0; k < 3; k++) step_commit(1'b1, 32'h2000 + 32'(4 * k), rand_inst(), 1'b0);
        step_commit(1'b1, 32'h200c, TB_ECALL, 1'b0);
        check_status("after_abort");
        drain_check("after_abort_drain", 20, -1, -1);

        // Immediate ebreak as the only commit.
        apply_reset();
        step_commit(1'b1, 32'h4000_0000, TB_EBREAK, 1'b0);
        check_status("single");
        drain_check("single_drain", 0, -1, -1);
        drain_check("single_redrain", 50, 0, -1);

        // Randomized rounds.
        for (int r = 0; r < 8; r++) begin
            apply_reset();
            pc = $urandom;
            for (int k = 0; k < int'($urandom_range(1, 40)); k++) begin
                pc = pc + 32'd4;
                step_commit($urandom_range(0, 3) != 0, pc,
                            ($urandom_range(0, 29) == 0) ? TB_ECALL : rand_inst(),
                            !model_halted && ($urandom_range(0, 7) == 0));
            end
            if (!model_halted) begin
                step_commit(1'b1, pc + 32'd4,
                            ($urandom_range(0, 1) == 1) ? TB_EBREAK : TB_ECALL, 1'b0);
            end
            check_status($sformatf("rnd%0d", r));
            drain_check($sformatf("rnd%0d_drain", r), 30, -1, -1);
            drain_check($sformatf("rnd%0d_redrain", r), 10, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
